// File: rtl/alu_core_pkg.sv
// -----------------------------------------------------------------------------
// alu_core_pkg
//   Shared ALU opcode encodings for alu_core and its iterative unit, plus a
//   helper that classifies an opcode as multi-cycle.
//   Optional feature macro: ALU_DIV_EN (divider on alu_div).
// -----------------------------------------------------------------------------
package alu_core_pkg;

   localparam logic [3:0] alu_none   = 4'd0;
   localparam logic [3:0] alu_pass_a = 4'd1;
   localparam logic [3:0] alu_pass_b = 4'd2;
   localparam logic [3:0] alu_add    = 4'd3;
   localparam logic [3:0] alu_sub    = 4'd4;
   localparam logic [3:0] alu_inc    = 4'd5;
   localparam logic [3:0] alu_dec    = 4'd6;
   localparam logic [3:0] alu_shl    = 4'd7;
   localparam logic [3:0] alu_shr    = 4'd8;
   localparam logic [3:0] alu_mul    = 4'd9;
   localparam logic [3:0] alu_div    = 4'd10;

   // Ops handled by alu_iter (WIDTH iterations) rather than in one cycle.
   function automatic logic is_iter_op(input logic [3:0] op);
`ifdef ALU_DIV_EN
      return (op == alu_mul) || (op == alu_div);
`else
      return (op == alu_mul);
`endif
   endfunction

endpackage

// File: rtl/alu_core_iter.sv
// -----------------------------------------------------------------------------
// alu_iter
//   Iterative unit: LSB-first shift-add multiplier and, with ALU_DIV_EN defined,
//   a restoring unsigned divider. One iteration per step_i; the caller counts
//   WIDTH steps.
//   Ports: clk, rstn (sync, active low), load_i (capture operands),
//          step_i (one iteration), div_i (ALU_DIV_EN only: select divide),
//          a_i/b_i operands, res_o (product low bits or quotient).
// -----------------------------------------------------------------------------
module alu_iter
   import alu_core_pkg::*;
#(
   parameter int WIDTH = 19
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             load_i,
   input  logic             step_i,
`ifdef ALU_DIV_EN
   input  logic             div_i,
`endif
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] res_o
);

   // Multiply: acc = partial product, mcand shifts left, mplier shifts right.
   // Divide:   acc = partial remainder, mcand = divisor, mplier = dividend
   //           shifting out MSB-first while quotient bits shift in at the LSB.
   logic [WIDTH-1:0] acc_q, mcand_q, mplier_q;

`ifdef ALU_DIV_EN
   logic             div_q;
   logic [WIDTH:0]   rem_sh;
   assign rem_sh = {acc_q, mplier_q[WIDTH-1]};
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
`ifdef ALU_DIV_EN
         div_q    <= 1'b0;
`endif
      end else if (load_i) begin
         acc_q <= '0;
`ifdef ALU_DIV_EN
         div_q    <= div_i;
         mcand_q  <= div_i ? b_i : a_i;
         mplier_q <= div_i ? a_i : b_i;
`else
         mcand_q  <= a_i;
         mplier_q <= b_i;
`endif
      end else if (step_i) begin
`ifdef ALU_DIV_EN
         if (div_q) begin
            // Divisor 0 always "fits", so the quotient saturates to all ones.
            if (rem_sh >= {1'b0, mcand_q}) begin
               acc_q    <= WIDTH'(rem_sh - {1'b0, mcand_q});
               mplier_q <= {mplier_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_q    <= rem_sh[WIDTH-1:0];
               mplier_q <= {mplier_q[WIDTH-2:0], 1'b0};
            end
         end else
`endif
         begin
            if (mplier_q[0]) acc_q <= acc_q + mcand_q;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
         end
      end
   end

`ifdef ALU_DIV_EN
   assign res_o = div_q ? mplier_q : acc_q;
`else
   assign res_o = acc_q;
`endif

endmodule

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
//   Sequential ALU between the A/B bus muxes and the C bus. Latches operands and
//   opcode on an accepted start, runs single-cycle ops or the iterative unit,
//   and drives a registered result plus Z flag with a one-cycle done pulse.
//   Optional feature macro: ALU_DIV_EN (restoring divider for alu_div).
//   Ports: clk, rstn (sync, active low), start, ALU_OP[3:0], a_in, b_in,
//          c_out (result, held), z_flag (result==0, held), busy, done.
// -----------------------------------------------------------------------------
module alu_core
   import alu_core_pkg::*;
#(
   parameter int WIDTH = 19,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             start,
   input  logic [3:0]       ALU_OP,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   output logic [WIDTH-1:0] c_out,
   output logic             z_flag,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {ST_IDLE, ST_ITER, ST_DONE} state_e;

   state_e           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [3:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q, c_q;
   logic             z_q, busy_q, done_q;
   logic [WIDTH-1:0] sc_res, iter_res, res;
   logic             accept;

   // Outputs are registered, so they trail the state by one edge; the done
   // cycle is spent back in IDLE with done_q high and must still block start.
   assign accept = (state_q == ST_IDLE) && start && !done_q;

   alu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk    (clk),
      .rstn   (rstn),
      .load_i (accept && is_iter_op(ALU_OP)),
      .step_i (state_q == ST_ITER),
`ifdef ALU_DIV_EN
      .div_i  (ALU_OP == alu_div),
`endif
      .a_i    (a_in),
      .b_i    (b_in),
      .res_o  (iter_res)
   );

   always_comb begin
      sc_res = '0;
      case (op_q)
         alu_pass_a: sc_res = a_q;
         alu_pass_b: sc_res = b_q;
         alu_add:    sc_res = a_q + b_q;
         alu_sub:    sc_res = a_q - b_q;
         alu_inc:    sc_res = a_q + WIDTH'(1);
         alu_dec:    sc_res = a_q - WIDTH'(1);
         alu_shl:    sc_res = (32'(b_q[4:0]) >= WIDTH) ? '0 : (a_q << b_q[4:0]);
         alu_shr:    sc_res = (32'(b_q[4:0]) >= WIDTH) ? '0 : (a_q >> b_q[4:0]);
         default:    sc_res = '0;
      endcase
   end

   assign res = is_iter_op(op_q) ? iter_res : sc_res;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         op_q    <= alu_none;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= '0;
         z_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               busy_q <= accept;
               if (accept) begin
                  op_q    <= ALU_OP;
                  a_q     <= a_in;
                  b_q     <= b_in;
                  cnt_q   <= '0;
                  state_q <= is_iter_op(ALU_OP) ? ST_ITER : ST_DONE;
               end
            end
            ST_ITER: begin
               if (cnt_q == CNT_W'(WIDTH - 1)) begin
                  cnt_q   <= '0;
                  state_q <= ST_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            ST_DONE: begin
               c_q     <= res;
               z_q     <= (res == '0);
               done_q  <= 1'b1;
               state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign c_out  = c_q;
   assign z_flag = z_q;
   assign busy   = busy_q;
   assign done   = done_q;

endmodule

// File: tb/tb_alu_core.sv
module tb_alu_core;
   import alu_core_pkg::*;

   localparam int W = 19;

   logic          clk = 1'b0;
   logic          rstn, start;
   logic [3:0]    ALU_OP;
   logic [W-1:0]  a_in, b_in, c_out;
   logic          z_flag, busy, done;

   int n_vec = 0;
   int n_err = 0;
   bit chk_en = 0;

   alu_core #(.WIDTH(W), .CNT_W(5)) dut (
      .clk(clk), .rstn(rstn), .start(start), .ALU_OP(ALU_OP),
      .a_in(a_in), .b_in(b_in), .c_out(c_out), .z_flag(z_flag),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [W-1:0] model_res(input logic [3:0] op,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
      longint la, lb, r;
      la = longint'(a);
      lb = longint'(b);
      r  = 0;
      case (op)
         alu_pass_a: r = la;
         alu_pass_b: r = lb;
         alu_add:    r = la + lb;
         alu_sub:    r = la - lb;
         alu_inc:    r = la + 1;
         alu_dec:    r = la - 1;
         alu_shl:    r = (int'(b[4:0]) >= W) ? 0 : (la << b[4:0]);
         alu_shr:    r = (int'(b[4:0]) >= W) ? 0 : (la >> b[4:0]);
         alu_mul:    r = la * lb;
`ifdef ALU_DIV_EN
         alu_div:    r = (lb == 0) ? ((64'd1 << W) - 1) : (la / lb);
`endif
         default:    r = 0;
      endcase
      return r[W-1:0];
   endfunction

   function automatic int model_lat(input logic [3:0] op);
`ifdef ALU_DIV_EN
      if (op == alu_mul || op == alu_div) return W + 1;
`else
      if (op == alu_mul) return W + 1;
`endif
      return 1;
   endfunction

   // Model state: edges remaining until completion, pending result, held outputs.
   int           m_rem  = 0;
   bit           m_done = 0;
   logic [W-1:0] m_res  = '0;
   logic [W-1:0] m_c    = '0;
   bit           m_z    = 0;

   always @(posedge clk) begin
      if (!rstn) begin
         m_rem = 0; m_done = 0; m_c = '0; m_z = 0;
      end else if (m_done) begin
         m_done = 0;
      end else if (m_rem > 0) begin
         m_rem--;
         if (m_rem == 0) begin
            m_done = 1; m_c = m_res; m_z = (m_res == '0);
         end
      end else if (start) begin
         m_res = model_res(ALU_OP, a_in, b_in);
         m_rem = model_lat(ALU_OP);
      end
   end

   // Compare process: every cycle once out of the initial reset.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("done",   32'(done),   32'(m_done));
         chk("busy",   32'(busy),   32'((m_rem > 0) || m_done));
         chk("c_out",  32'(c_out),  32'(m_c));
         chk("z_flag", 32'(z_flag), 32'(m_z));
      end
   end

   // cyc = cycles after the accepting edge until done is seen (1 or W+1).
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit disturb, output int cyc);
      @(negedge clk);
      ALU_OP = op; a_in = a; b_in = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 64) begin
         @(negedge clk);
         cyc++;
         if (disturb && cyc == 3) begin
            a_in = ~a; b_in = ~b; ALU_OP = alu_add; start = 1'b1;
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      if (done !== 1'b1) begin
         n_vec++; n_err++;
         $display("FAIL timeout op=%0d: no done within 64 cycles", op);
      end
   endtask

   int cyc;
   int seen;

   initial begin
      // 1: reset with start held high
      rstn = 1'b0; start = 1'b1; ALU_OP = alu_add; a_in = 19'h12345; b_in = 19'h00042;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_c_out", 32'(c_out), 0);
      chk("rst_z",     32'(z_flag), 0);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_done",  32'(done), 0);
      chk_en = 1;
      rstn = 1'b1; start = 1'b0;

      // 2: add wraps to zero, then start during done is ignored
      run_op(alu_add, 19'h7FFFF, 19'd1, 0, cyc);
      chk("add_lat", 32'(cyc), 1);
      chk("add_c", 32'(c_out), 0);
      chk("add_z", 32'(z_flag), 1);
      ALU_OP = alu_pass_a; a_in = 19'h00777; start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("start_in_done_busy", 32'(busy), 0);
      chk("start_in_done_c", 32'(c_out), 0);
      repeat (2) @(negedge clk);

      run_op(alu_sub, 19'd5, 19'd7, 0, cyc);
      chk("sub_c", 32'(c_out), 32'h7FFFE);
      chk("sub_z", 32'(z_flag), 0);

      // 3: multiply with bus changes and a re-pulsed start mid-op
      run_op(alu_mul, 19'd300, 19'd400, 1, cyc);
      chk("mul_lat", 32'(cyc), W + 1);
      chk("mul_c", 32'(c_out), 32'h1D4C0);
      run_op(alu_mul, 19'h7FFFF, 19'h7FFFF, 0, cyc);
      chk("mul_max_c", 32'(c_out), 1);

      // 4: shifts incl. boundary amounts
      run_op(alu_shr, 19'd1020, 19'd2, 0, cyc);
      chk("shr_c", 32'(c_out), 255);
      run_op(alu_shl, 19'd1, 19'd19, 0, cyc);
      chk("shl19_c", 32'(c_out), 0);
      chk("shl19_z", 32'(z_flag), 1);
      run_op(alu_shl, 19'd1, 19'd18, 0, cyc);
      chk("shl18_c", 32'(c_out), 32'h40000);
      run_op(alu_shr, 19'h7FFFF, 19'h0001F, 0, cyc);
      chk("shr31_c", 32'(c_out), 0);

      // misc single-cycle ops and an undefined opcode
      run_op(alu_inc, 19'h7FFFF, 19'd0, 0, cyc);
      chk("inc_c", 32'(c_out), 0);
      run_op(alu_dec, 19'd0, 19'd0, 0, cyc);
      chk("dec_c", 32'(c_out), 32'h7FFFF);
      run_op(alu_pass_b, 19'd3, 19'h2ABCD, 0, cyc);
      chk("pass_b_c", 32'(c_out), 32'h2ABCD);
      run_op(alu_pass_a, 19'h1357, 19'd0, 0, cyc);
      chk("pass_a_c", 32'(c_out), 32'h1357);
      run_op(4'hF, 19'h11111, 19'h22222, 0, cyc);
      chk("undef_lat", 32'(cyc), 1);
      chk("undef_c", 32'(c_out), 0);
      chk("undef_z", 32'(z_flag), 1);

      // 5: reset during iteration 5 of a multiply
      @(negedge clk);
      ALU_OP = alu_mul; a_in = 19'd9; b_in = 19'd9; start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      seen = 0;
      for (int i = 0; i < W + 6; i++) begin
         @(negedge clk);
         if (done === 1'b1) seen++;
      end
      chk("midrst_no_done", 32'(seen), 0);
      run_op(alu_add, 19'd2, 19'd3, 0, cyc);
      chk("post_rst_add", 32'(c_out), 5);

      // 6: divide
`ifdef ALU_DIV_EN
      run_op(alu_div, 19'd1020, 19'd4, 0, cyc);
      chk("div_lat", 32'(cyc), W + 1);
      chk("div_c", 32'(c_out), 255);
      run_op(alu_div, 19'd7, 19'd0, 0, cyc);
      chk("div0_c", 32'(c_out), 32'h7FFFF);
      chk("div0_z", 32'(z_flag), 0);
`else
      run_op(alu_div, 19'd1020, 19'd4, 0, cyc);
      chk("div_off_lat", 32'(cyc), 1);
      chk("div_off_c", 32'(c_out), 0);
      chk("div_off_z", 32'(z_flag), 1);
`endif

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
